// File: rtl/gmii_frame_checker.sv
// GMII rx frame checker: preamble/SFD align, CRC-32 check, FCS-stripped payload 4 beats late; no backpressure.
// Per-frame status strobe one clock after end of frame; stat_good/stat_bad exist when GMII_FRAME_CHECKER_STATS_EN is defined.
package gmii_frame_checker_pkg;
  typedef struct packed {
    logic       dvalid;
    logic       en;
    logic       er;
    logic [7:0] data;
  } gmii_bus_t;
endpackage

module gmii_frame_checker
  import gmii_frame_checker_pkg::*;
#(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic        clk_mac,
  input  logic        rst_mac,
  input  gmii_bus_t   gmii_bus,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        frame_valid,
  output logic [15:0] frame_len,
  output logic        frame_fcs_ok,
  output logic        frame_runt,
  output logic        frame_giant,
  output logic        frame_phy_err,
  output logic        frame_preamble_err
`ifdef GMII_FRAME_CHECKER_STATS_EN
  ,
  output logic [31:0] stat_good,
  output logic [31:0] stat_bad
`endif
);

  localparam logic [15:0] MIN_L   = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L   = 16'(MAX_LEN);
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    DROP,
    IDLE,
    PREAMBLE,
    PREAMBLE_BAD,
    FRAME
  } state_t;

  state_t          state;
  logic [31:0]     crc;
  logic [15:0]     len;
  logic            phy;
  logic [3:0][7:0] dline;
  logic [2:0]      dcnt;

  logic            beat;
  logic            report;
  logic [15:0]     rep_len;
  logic            rep_fcs_ok;
  logic            rep_pre;
  logic            rep_runt;
  logic            rep_giant;
  logic            rep_good;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign beat   = gmii_bus.dvalid;
  assign report = beat && !gmii_bus.en && (state == FRAME || state == PREAMBLE_BAD);

  // A rejected preamble reports as an empty frame with only the preamble flag meaningful.
  always_comb begin
    rep_len    = len;
    rep_fcs_ok = (len >= 16'd4) && (crc == RESIDUE);
    rep_pre    = 1'b0;
    if (state == PREAMBLE_BAD) begin
      rep_len    = 16'd0;
      rep_fcs_ok = 1'b0;
      rep_pre    = 1'b1;
    end
    rep_runt  = rep_len < MIN_L;
    rep_giant = rep_len > MAX_L;
    rep_good  = rep_fcs_ok && !rep_runt && !rep_giant && !phy && !rep_pre;
  end

  always_ff @(posedge clk_mac or posedge rst_mac) begin
    if (rst_mac) begin
      state              <= DROP;
      crc                <= 32'hFFFFFFFF;
      len                <= 16'd0;
      phy                <= 1'b0;
      dline              <= '0;
      dcnt               <= 3'd0;
      out_valid          <= 1'b0;
      out_data           <= 8'd0;
      frame_valid        <= 1'b0;
      frame_len          <= 16'd0;
      frame_fcs_ok       <= 1'b0;
      frame_runt         <= 1'b0;
      frame_giant        <= 1'b0;
      frame_phy_err      <= 1'b0;
      frame_preamble_err <= 1'b0;
`ifdef GMII_FRAME_CHECKER_STATS_EN
      stat_good          <= 32'd0;
      stat_bad           <= 32'd0;
`endif
    end else begin
      out_valid   <= 1'b0;
      frame_valid <= 1'b0;

      if (report) begin
        frame_valid        <= 1'b1;
        frame_len          <= rep_len;
        frame_fcs_ok       <= rep_fcs_ok;
        frame_runt         <= rep_runt;
        frame_giant        <= rep_giant;
        frame_phy_err      <= phy;
        frame_preamble_err <= rep_pre;
`ifdef GMII_FRAME_CHECKER_STATS_EN
        if (rep_good) stat_good <= stat_good + 32'd1;
        else          stat_bad  <= stat_bad + 32'd1;
`endif
      end

      if (beat) begin
        case (state)
          DROP: begin
            if (!gmii_bus.en) state <= IDLE;
          end

          IDLE: begin
            if (gmii_bus.en) begin
              phy <= gmii_bus.er;
              if (gmii_bus.data == 8'h55) begin
                state <= PREAMBLE;
              end else if (gmii_bus.data == 8'hD5) begin
                state <= FRAME;
                crc   <= 32'hFFFFFFFF;
                len   <= 16'd0;
                dcnt  <= 3'd0;
              end else begin
                state <= PREAMBLE_BAD;
              end
            end
          end

          PREAMBLE: begin
            if (!gmii_bus.en) begin
              state <= IDLE;
            end else begin
              phy <= phy | gmii_bus.er;
              if (gmii_bus.data == 8'hD5) begin
                state <= FRAME;
                crc   <= 32'hFFFFFFFF;
                len   <= 16'd0;
                dcnt  <= 3'd0;
              end else if (gmii_bus.data != 8'h55) begin
                state <= PREAMBLE_BAD;
              end
            end
          end

          PREAMBLE_BAD: begin
            if (!gmii_bus.en) state <= IDLE;
            else              phy   <= phy | gmii_bus.er;
          end

          FRAME: begin
            if (gmii_bus.en) begin
              crc <= crc_byte(crc, gmii_bus.data);
              len <= (len == 16'hFFFF) ? len : len + 16'd1;
              phy <= phy | gmii_bus.er;
              // Emitting only once four newer bytes exist keeps the FCS from ever leaving.
              if (dcnt == 3'd4) begin
                out_valid <= 1'b1;
                out_data  <= dline[3];
              end else begin
                dcnt <= dcnt + 3'd1;
              end
              dline <= {dline[2:0], gmii_bus.data};
            end else begin
              state <= IDLE;
            end
          end

          default: state <= DROP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gmii_frame_checker.sv
// Directed + randomized bench for gmii_frame_checker against a frame-level reference model.
module tb_gmii_frame_checker;
  import gmii_frame_checker_pkg::*;

  logic        clk_mac = 1'b0;
  logic        rst_mac;
  gmii_bus_t   gmii_bus;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        frame_valid;
  logic [15:0] frame_len;
  logic        frame_fcs_ok;
  logic        frame_runt;
  logic        frame_giant;
  logic        frame_phy_err;
  logic        frame_preamble_err;
`ifdef GMII_FRAME_CHECKER_STATS_EN
  logic [31:0] stat_good;
  logic [31:0] stat_bad;
`endif

  gmii_frame_checker #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
    .clk_mac            (clk_mac),
    .rst_mac            (rst_mac),
    .gmii_bus           (gmii_bus),
    .out_valid          (out_valid),
    .out_data           (out_data),
    .frame_valid        (frame_valid),
    .frame_len          (frame_len),
    .frame_fcs_ok       (frame_fcs_ok),
    .frame_runt         (frame_runt),
    .frame_giant        (frame_giant),
    .frame_phy_err      (frame_phy_err),
    .frame_preamble_err (frame_preamble_err)
`ifdef GMII_FRAME_CHECKER_STATS_EN
    ,
    .stat_good          (stat_good),
    .stat_bad           (stat_bad)
`endif
  );

  initial forever #4 clk_mac = ~clk_mac;

  typedef struct {
    int len;
    bit fcs_ok;
    bit runt;
    bit giant;
    bit phy;
    bit pre;
    int fv_cyc;
    int ov_cyc;
  } rep_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_ov_cyc = -1;
  bit          pace = 0;
  logic [7:0]  got_q[$];
  rep_t        rep_q[$];
  rep_t        mon_r;
  logic [7:0]  bq[$];
  logic [7:0]  bq_a[$];
  logic [7:0]  bq_b[$];
  logic [31:0] crc_tbl[256];
  int          exp_good = 0;
  int          exp_bad = 0;

  initial forever begin
    @(posedge clk_mac);
    cyc++;
  end

  initial forever begin
    @(negedge clk_mac);
    if (!rst_mac) begin
      if (out_valid) begin
        got_q.push_back(out_data);
        last_ov_cyc = cyc;
      end
      if (frame_valid) begin
        mon_r.len    = int'(frame_len);
        mon_r.fcs_ok = frame_fcs_ok;
        mon_r.runt   = frame_runt;
        mon_r.giant  = frame_giant;
        mon_r.phy    = frame_phy_err;
        mon_r.pre    = frame_preamble_err;
        mon_r.fv_cyc = cyc;
        mon_r.ov_cyc = last_ov_cyc;
        rep_q.push_back(mon_r);
      end
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Table-driven IEEE 802.3 CRC-32 with final inversion, i.e. the value a transmitter places in the FCS.
  function automatic logic [31:0] crc32(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) c = crc_tbl[(c[7:0] ^ q[i])] ^ (c >> 8);
    return ~c;
  endfunction

  task automatic build(input int plen, input bit corrupt);
    logic [31:0] c;
    bq.delete();
    for (int i = 0; i < plen; i++) bq.push_back(8'($urandom));
    c = crc32(bq);
    for (int i = 0; i < 4; i++) bq.push_back(c[8*i +: 8]);
    if (corrupt) bq[bq.size()-1] = bq[bq.size()-1] ^ 8'h01;
  endtask

  task automatic beat(input bit en, input bit er, input logic [7:0] d);
    gmii_bus.dvalid = 1'b1;
    gmii_bus.en     = en;
    gmii_bus.er     = er;
    gmii_bus.data   = d;
    @(posedge clk_mac); #1;
    if (pace) begin
      gmii_bus.dvalid = 1'b0;
      gmii_bus.en     = 1'($urandom);
      gmii_bus.er     = 1'($urandom);
      gmii_bus.data   = 8'($urandom);
      @(posedge clk_mac); #1;
    end
  endtask

  task automatic send_frame(input int npre, input int er_idx);
    for (int i = 0; i < npre; i++) beat(1'b1, 1'b0, 8'h55);
    beat(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < bq.size(); i++) beat(1'b1, i == er_idx, bq[i]);
    beat(1'b0, 1'b0, 8'h00);
  endtask

  task automatic wait_rep(input string tag, input int n);
    for (int i = 0; i < 40 && rep_q.size() < n; i++) @(posedge clk_mac);
    @(negedge clk_mac); #1;
    chk({tag, "_rep_cnt"}, rep_q.size(), n);
  endtask

  task automatic check_frame(input string tag, input bit phy);
    int          n;
    int          exp_len;
    int          nout;
    int          badb;
    bit          exp_fcs;
    bit          exp_runt;
    bit          exp_giant;
    logic [31:0] fcs_field;
    logic [7:0]  pl[$];
    rep_t        r;
    n       = bq.size();
    exp_len = (n > 65535) ? 65535 : n;
    nout    = (n > 4) ? n - 4 : 0;
    for (int i = 0; i < nout; i++) pl.push_back(bq[i]);
    exp_fcs = 1'b0;
    if (n >= 4) begin
      fcs_field = {bq[n-1], bq[n-2], bq[n-3], bq[n-4]};
      exp_fcs   = (fcs_field == crc32(pl));
    end
    exp_runt  = exp_len < 64;
    exp_giant = exp_len > 1518;
    if (exp_fcs && !exp_runt && !exp_giant && !phy) exp_good++;
    else exp_bad++;
    badb = 0;
    for (int i = 0; i < nout; i++) begin
      if (got_q.size() == 0) badb++;
      else if (got_q.pop_front() !== bq[i]) badb++;
    end
    chk({tag, "_payload_bad_bytes"}, badb, 0);
    if (rep_q.size() == 0) return;
    r = rep_q.pop_front();
    chk({tag, "_len"}, r.len, exp_len);
    chk({tag, "_fcs_ok"}, r.fcs_ok, exp_fcs);
    chk({tag, "_runt"}, r.runt, exp_runt);
    chk({tag, "_giant"}, r.giant, exp_giant);
    chk({tag, "_phy"}, r.phy, phy);
    chk({tag, "_pre"}, r.pre, 0);
    if (nout > 0) chk({tag, "_ov_before_fv"}, r.fv_cyc > r.ov_cyc, 1);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_stray_bytes"}, got_q.size(), 0);
    chk({tag, "_stray_reps"}, rep_q.size(), 0);
    got_q.delete();
    rep_q.delete();
  endtask

  initial begin
    rep_t r;
    int   plen;
    int   npre;
    int   er_idx;
    logic [31:0] c;
`ifdef GMII_FRAME_CHECKER_STATS_EN
    logic [31:0] g0;
    logic [31:0] b0;
`endif
    for (int n = 0; n < 256; n++) begin
      c = 32'(n);
      for (int k = 0; k < 8; k++) c = c[0] ? (32'hEDB88320 ^ (c >> 1)) : (c >> 1);
      crc_tbl[n] = c;
    end

    rst_mac  = 1'b1;
    gmii_bus = '0;
    repeat (3) @(posedge clk_mac);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_frame_len", frame_len, 0);
    chk("rst_flags", {frame_fcs_ok, frame_runt, frame_giant, frame_phy_err, frame_preamble_err}, 0);
`ifdef GMII_FRAME_CHECKER_STATS_EN
    chk("rst_stat_good", stat_good, 0);
    chk("rst_stat_bad", stat_bad, 0);
`endif
    rst_mac = 1'b0;
    beat(1'b0, 1'b0, 8'h00);
    beat(1'b0, 1'b0, 8'h00);

    build(60, 1'b0);
    send_frame(7, -1);
    wait_rep("good64", 1);
    check_frame("good64", 1'b0);
    check_quiet("good64");

    bq[bq.size()-1] = bq[bq.size()-1] ^ 8'h01;
    send_frame(7, -1);
    wait_rep("badfcs", 1);
    check_frame("badfcs", 1'b0);
    check_quiet("badfcs");

    beat(1'b1, 1'b0, 8'h55);
    beat(1'b1, 1'b0, 8'h55);
    beat(1'b1, 1'b0, 8'hA5);
    repeat (20) beat(1'b1, 1'b0, 8'($urandom));
    beat(1'b0, 1'b0, 8'h00);
    wait_rep("prebad", 1);
    if (rep_q.size() > 0) begin
      r = rep_q.pop_front();
      chk("prebad_pre", r.pre, 1);
      chk("prebad_len", r.len, 0);
      chk("prebad_fcs_ok", r.fcs_ok, 0);
    end
    exp_bad++;
    check_quiet("prebad");

    beat(1'b1, 1'b0, 8'h55);
    beat(1'b1, 1'b0, 8'h55);
    beat(1'b0, 1'b0, 8'h00);
    repeat (6) @(posedge clk_mac);
    #1;
    check_quiet("pre_abort");

    build(1600, 1'b0);
    send_frame(7, 100);
    wait_rep("giant", 1);
    check_frame("giant", 1'b1);
    check_quiet("giant");

    build(6, 1'b0);
    send_frame(7, -1);
    wait_rep("runt", 1);
    check_frame("runt", 1'b0);
    check_quiet("runt");

    build(60, 1'b0);
    for (int i = 0; i < 7; i++) beat(1'b1, 1'b0, 8'h55);
    beat(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 30; i++) beat(1'b1, 1'b0, bq[i]);
    rst_mac = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_frame_valid", frame_valid, 0);
    got_q.delete();
    rep_q.delete();
    exp_good = 0;
    exp_bad  = 0;
    beat(1'b1, 1'b0, bq[30]);
    beat(1'b1, 1'b0, bq[31]);
    rst_mac = 1'b0;
    for (int i = 32; i < bq.size(); i++) beat(1'b1, 1'b0, bq[i]);
    beat(1'b0, 1'b0, 8'h00);
    repeat (8) @(posedge clk_mac);
    #1;
    check_quiet("midrst");
    build(60, 1'b0);
    send_frame(7, -1);
    wait_rep("after_rst", 1);
    check_frame("after_rst", 1'b0);
    check_quiet("after_rst");

`ifdef GMII_FRAME_CHECKER_STATS_EN
    g0 = stat_good;
    b0 = stat_bad;
`endif
    pace = 1'b1;
    build(60, 1'b0);
    bq_a = bq;
    build(60, 1'b0);
    bq_b = bq;
    bq = bq_a;
    send_frame(7, -1);
    bq = bq_b;
    send_frame(0, -1);
    wait_rep("paced", 2);
    bq = bq_a;
    check_frame("paced_a", 1'b0);
    bq = bq_b;
    check_frame("paced_b", 1'b0);
    check_quiet("paced");
`ifdef GMII_FRAME_CHECKER_STATS_EN
    chk("paced_stat_good_delta", stat_good - g0, 2);
    chk("paced_stat_bad_delta", stat_bad - b0, 0);
`endif
    pace = 1'b0;

    for (int t = 0; t < 14; t++) begin
      pace = 1'($urandom);
      npre = $urandom_range(0, 8);
      if ($urandom_range(0, 3) == 0) begin
        bq.delete();
        plen = $urandom_range(0, 3);
        for (int i = 0; i < plen; i++) bq.push_back(8'($urandom));
      end else begin
        build($urandom_range(0, 80), $urandom_range(0, 2) == 0);
      end
      er_idx = ($urandom_range(0, 4) == 0 && bq.size() > 0) ? $urandom_range(0, bq.size() - 1) : -1;
      send_frame(npre, er_idx);
      wait_rep("rnd", 1);
      check_frame("rnd", er_idx >= 0);
      check_quiet("rnd");
    end
    pace = 1'b0;

`ifdef GMII_FRAME_CHECKER_STATS_EN
    chk("stat_good_total", stat_good, exp_good);
    chk("stat_bad_total", stat_bad, exp_bad);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
